fpu_add_arbiter: RTL

Shares one single-precision adder datapath between two requesters. Accepts packed IEEE-754 operand pairs, arbitrates round-robin, and decomposes the operands into the sign/exponent/fraction and metadata fields the adder consumes. Sequences the adder's valid/ready handshake and resolves zero, infinity and NaN operands without using the adder. Returns each result on one shared response port with a requester ID and a watchdog error flag. Sits between the FPU front-end request queues and the adder.

---
 rtl/fpu_add_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_add_arbiter
// Purpose  : Round-robin front end sharing one single-precision adder between
//            two requesters. Unpacks IEEE-754 operands into adder fields,
//            resolves zero/inf/NaN operands locally, sequences the adder
//            handshake with a watchdog, and returns results on one port.
// Revision : 1.0  initial release
// ============================================================================
module fpu_add_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_x_i,
    input  logic [31:0] req0_y_i,
    input  logic        req0_sub_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_x_i,
    input  logic [31:0] req1_y_i,
    input  logic        req1_sub_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_z_o,
    output logic        rsp_inf_o,
    output logic        rsp_nan_o,
    output logic        rsp_err_o,

    output logic        add_valid_o,
    input  logic        add_ready_i,
    output logic        add_x_sign_o,
    output logic        add_y_sign_o,
    output logic [7:0]  add_x_exp_o,
    output logic [7:0]  add_y_exp_o,
    output logic [22:0] add_x_frac_o,
    output logic [22:0] add_y_frac_o,
    output logic        add_x_greater_o,
    output logic [7:0]  add_exp_shift_o,
    output logic        add_infinity_o,
    output logic        add_nan_o,
    input  logic [31:0] add_z_i,
    input  logic        add_z_infinity_i,
    input  logic        add_z_nan_i
);

    localparam logic [31:0] C_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  C_WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_ptr;
    logic [7:0]  r_wd_cnt;

    logic        r_x_sign;
    logic        r_y_sign;
    logic [7:0]  r_x_exp;
    logic [7:0]  r_y_exp;
    logic [22:0] r_x_frac;
    logic [22:0] r_y_frac;
    logic        r_x_greater;
    logic [7:0]  r_exp_shift;

    logic        r_rsp_id;
    logic [31:0] r_rsp_z;
    logic        r_rsp_inf;
    logic        r_rsp_nan;
    logic        r_rsp_err;

    // Arbitration: pointer breaks ties, a lone requester always wins
    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_grant0 = w_idle & req0_valid_i & (~req1_valid_i | ~r_ptr);
    assign w_grant1 = w_idle & req1_valid_i & (~req0_valid_i |  r_ptr);
    assign w_accept = w_grant0 | w_grant1;

    // Operand selection and field extraction (y sign flipped for subtract)
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_sub;
    logic        w_x_sign;
    logic        w_y_sign;
    logic [7:0]  w_x_exp;
    logic [7:0]  w_y_exp;
    logic [22:0] w_x_frac;
    logic [22:0] w_y_frac;

    assign w_x      = w_grant1 ? req1_x_i   : req0_x_i;
    assign w_y      = w_grant1 ? req1_y_i   : req0_y_i;
    assign w_sub    = w_grant1 ? req1_sub_i : req0_sub_i;
    assign w_x_sign = w_x[31];
    assign w_y_sign = w_y[31] ^ w_sub;
    assign w_x_exp  = w_x[30:23];
    assign w_y_exp  = w_y[30:23];
    assign w_x_frac = w_x[22:0];
    assign w_y_frac = w_y[22:0];

    // Magnitude ordering and alignment distance for the adder
    logic        w_x_greater;
    logic [7:0]  w_exp_shift;

    assign w_x_greater = ({w_x_exp, w_x_frac} >= {w_y_exp, w_y_frac});
    assign w_exp_shift = (w_x_exp >= w_y_exp) ? (w_x_exp - w_y_exp)
                                              : (w_y_exp - w_x_exp);

    // Operand classes; a zero exponent also covers flushed denormals
    logic w_x_zero;
    logic w_y_zero;
    logic w_x_inf;
    logic w_y_inf;
    logic w_x_nan;
    logic w_y_nan;

    assign w_x_zero = (w_x_exp == 8'h00);
    assign w_y_zero = (w_y_exp == 8'h00);
    assign w_x_inf  = (w_x_exp == 8'hFF) & (w_x_frac == 23'd0);
    assign w_y_inf  = (w_y_exp == 8'hFF) & (w_y_frac == 23'd0);
    assign w_x_nan  = (w_x_exp == 8'hFF) & (w_x_frac != 23'd0);
    assign w_y_nan  = (w_y_exp == 8'hFF) & (w_y_frac != 23'd0);

    // Special-operand resolution in priority order; anything else uses the adder
    logic        w_bypass;
    logic [31:0] w_byp_z;
    logic        w_byp_inf;
    logic        w_byp_nan;

    always_comb begin
        w_bypass  = 1'b1;
        w_byp_z   = 32'd0;
        w_byp_inf = 1'b0;
        w_byp_nan = 1'b0;
        if (w_x_nan || w_y_nan) begin
            w_byp_z   = C_QNAN;
            w_byp_nan = 1'b1;
        end else if (w_x_inf && w_y_inf && (w_x_sign != w_y_sign)) begin
            w_byp_z   = C_QNAN;
            w_byp_nan = 1'b1;
        end else if (w_x_inf) begin
            w_byp_z   = {w_x_sign, 8'hFF, 23'd0};
            w_byp_inf = 1'b1;
        end else if (w_y_inf) begin
            w_byp_z   = {w_y_sign, 8'hFF, 23'd0};
            w_byp_inf = 1'b1;
        end else if (w_x_zero && w_y_zero) begin
            w_byp_z   = {w_x_sign & w_y_sign, 31'd0};
        end else if (w_x_zero) begin
            w_byp_z   = {w_y_sign, w_y_exp, w_y_frac};
        end else if (w_y_zero) begin
            w_byp_z   = {w_x_sign, w_x_exp, w_x_frac};
        end else begin
            w_bypass  = 1'b0;
        end
    end

    // Watchdog expiry is only meaningful while waiting on the adder
    logic w_in_wait;
    logic w_wd_expire;

    assign w_in_wait   = (r_state == ST_WAIT);
    assign w_wd_expire = w_in_wait & ~add_ready_i & (r_wd_cnt == C_WD_LAST);

    // Next-state logic for the request sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_bypass ? ST_RESPOND : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (add_ready_i || w_wd_expire) begin
                    w_state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round-robin pointer moves to the requester not just served
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= 1'b0;
        end else if ((r_state == ST_RESPOND) && rsp_ready_i) begin
            r_ptr <= ~r_rsp_id;
        end
    end

    // Watchdog counts WAIT cycles and restarts whenever WAIT is left
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= 8'd0;
        end else if (w_in_wait && !add_ready_i && !w_wd_expire) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end else begin
            r_wd_cnt <= 8'd0;
        end
    end

    // Adder operand fields latched on accept and held through WAIT
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_x_sign    <= 1'b0;
            r_y_sign    <= 1'b0;
            r_x_exp     <= 8'd0;
            r_y_exp     <= 8'd0;
            r_x_frac    <= 23'd0;
            r_y_frac    <= 23'd0;
            r_x_greater <= 1'b0;
            r_exp_shift <= 8'd0;
        end else if (w_accept) begin
            r_x_sign    <= w_x_sign;
            r_y_sign    <= w_y_sign;
            r_x_exp     <= w_x_exp;
            r_y_exp     <= w_y_exp;
            r_x_frac    <= w_x_frac;
            r_y_frac    <= w_y_frac;
            r_x_greater <= w_x_greater;
            r_exp_shift <= w_exp_shift;
        end
    end

    // Response register: bypass result on accept, adder or watchdog result in WAIT
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_id  <= 1'b0;
            r_rsp_z   <= 32'd0;
            r_rsp_inf <= 1'b0;
            r_rsp_nan <= 1'b0;
            r_rsp_err <= 1'b0;
        end else if (w_accept) begin
            r_rsp_id  <= w_grant1;
            r_rsp_z   <= w_byp_z;
            r_rsp_inf <= w_byp_inf;
            r_rsp_nan <= w_byp_nan;
            r_rsp_err <= 1'b0;
        end else if (w_in_wait && add_ready_i) begin
            r_rsp_z   <= add_z_i;
            r_rsp_inf <= add_z_infinity_i;
            r_rsp_nan <= add_z_nan_i;
            r_rsp_err <= 1'b0;
        end else if (w_wd_expire) begin
            r_rsp_z   <= C_QNAN;
            r_rsp_inf <= 1'b0;
            r_rsp_nan <= 1'b1;
            r_rsp_err <= 1'b1;
        end
    end

    assign req0_ready_o    = w_grant0;
    assign req1_ready_o    = w_grant1;

    assign rsp_valid_o     = (r_state == ST_RESPOND);
    assign rsp_id_o        = r_rsp_id;
    assign rsp_z_o         = r_rsp_z;
    assign rsp_inf_o       = r_rsp_inf;
    assign rsp_nan_o       = r_rsp_nan;
    assign rsp_err_o       = r_rsp_err;

    assign add_valid_o     = (r_state == ST_ISSUE);
    assign add_x_sign_o    = r_x_sign;
    assign add_y_sign_o    = r_y_sign;
    assign add_x_exp_o     = r_x_exp;
    assign add_y_exp_o     = r_y_exp;
    assign add_x_frac_o    = r_x_frac;
    assign add_y_frac_o    = r_y_frac;
    assign add_x_greater_o = r_x_greater;
    assign add_exp_shift_o = r_exp_shift;
    assign add_infinity_o  = 1'b0;
    assign add_nan_o       = 1'b0;

endmodule
`default_nettype wire
